// File: rtl/cdc_2phase_rx_fifo.sv
// cdc_2phase_rx_fifo: receive endpoint of a 2-phase (toggle) req/ack
// handshake. The incoming toggle is synchronised into o_clk. The bundled
// word is captured into a DEPTH-entry FIFO, and the toggle is acknowledged
// only once the word has a slot. Buffered words leave on a first-word
// fall-through valid/ready port.
// Optional build macro CDC_RX_LEVEL_EN adds the o_level and o_full status ports.
module cdc_2phase_rx_fifo #(
  parameter int data_widght = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   o_clk,
  input  logic                   o_rst,
  input  logic                   req_in,
  input  logic [data_widght-1:0] data_in,
  output logic                   ack_out,
  output logic [data_widght-1:0] o_data,
  output logic                   o_valid,
  input  logic                   o_ready
`ifdef CDC_RX_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_full
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_q, ack_d;
  logic                   valid_q, valid_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          wptr_q, wptr_d;
  logic [PW-1:0]          rptr_q, rptr_d;
  logic [data_widght-1:0] mem [DEPTH];

  logic req_s;
  logic pending_s;
  logic push_s;
  logic pop_s;

  // Handshake decode, pointer/count next-state.
  // A push needs room by the registered count. A pop needs a registered valid word.
  always_comb begin
    req_s     = sync_q[SYNC_STAGES-1];
    pending_s = req_s ^ ack_q;
    push_s    = pending_s && (count_q < DEPTH_C);
    pop_s     = valid_q && o_ready;

    ack_d = push_s ? ~ack_q : ack_q;

    if (push_s) begin
      wptr_d = (wptr_q == LAST_C) ? {PW{1'b0}} : wptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wptr_d = wptr_q;
    end

    if (pop_s) begin
      rptr_d = (rptr_q == LAST_C) ? {PW{1'b0}} : rptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rptr_d = rptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase

    valid_d = (count_d != {CW{1'b0}});
  end

  // Control state: synchroniser, ack toggle, pointers, count and valid flag.
  always_ff @(posedge o_clk or posedge o_rst) begin
    if (o_rst) begin
      sync_q  <= {SYNC_STAGES{1'b0}};
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      count_q <= {CW{1'b0}};
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], req_in};
      ack_q   <= ack_d;
      valid_q <= valid_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Storage array. It is deliberately not reset because its contents are
  // only observed while o_valid is 1.
  always_ff @(posedge o_clk) begin
    if (push_s) begin
      mem[wptr_q] <= data_in;
    end
  end

  assign ack_out = ack_q;
  assign o_valid = valid_q;
  assign o_data  = mem[rptr_q];

`ifdef CDC_RX_LEVEL_EN
  logic full_q;

  // Registered full flag, which tracks the count register.
  always_ff @(posedge o_clk or posedge o_rst) begin
    if (o_rst) begin
      full_q <= 1'b0;
    end else begin
      full_q <= (count_d == DEPTH_C);
    end
  end

  assign o_level = count_q;
  assign o_full  = full_q;
`endif

endmodule

// File: tb/tb_cdc_2phase_rx_fifo.sv
// Directed bench for cdc_2phase_rx_fifo with default parameters
// (8-bit data, DEPTH 4, 2 sync stages).
module tb_cdc_2phase_rx_fifo;

  logic       o_clk = 1'b0;
  logic       o_rst;
  logic       req_in;
  logic [7:0] data_in;
  logic       ack_out;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_ready;
`ifdef CDC_RX_LEVEL_EN
  logic [2:0] o_level;
  logic       o_full;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  cdc_2phase_rx_fifo #(
    .data_widght(8),
    .DEPTH(4),
    .SYNC_STAGES(2)
  ) dut (
    .o_clk(o_clk),
    .o_rst(o_rst),
    .req_in(req_in),
    .data_in(data_in),
    .ack_out(ack_out),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_ready(o_ready)
`ifdef CDC_RX_LEVEL_EN
    ,
    .o_level(o_level),
    .o_full(o_full)
`endif
  );

  always #5 o_clk = ~o_clk;

  typedef struct {
    logic       req;
    logic [7:0] data;
    logic       rdy;
    logic       exp_ack;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       vecs [9];
  logic [7:0] got [$];
  int         edges;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a word and toggle req. Then count o_clk edges until the matching ack arrives.
  task automatic send(input logic [7:0] d, output int n);
    @(negedge o_clk);
    data_in = d;
    req_in  = ~req_in;
    n = 0;
    while (ack_out !== req_in && n < 40) begin
      @(posedge o_clk);
      #1;
      n++;
    end
    check("ack_wait", 8'(ack_out), 8'(req_in));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // One-word handshakes with the consumer always ready.
    vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5};
    vecs[3] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A};
    vecs[8] = '{1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00};

    o_rst   = 1'b1;
    req_in  = 1'b0;
    data_in = 8'h00;
    o_ready = 1'b0;
    repeat (2) @(posedge o_clk);
    #1;
    check("reset_ack", 8'(ack_out), 8'h00);
    check("reset_valid", 8'(o_valid), 8'h00);
`ifdef CDC_RX_LEVEL_EN
    check("reset_level", 8'(o_level), 8'h00);
    check("reset_full", 8'(o_full), 8'h00);
`endif
    @(negedge o_clk);
    o_rst = 1'b0;

    // Table-driven single transfers.
    for (int i = 0; i < 9; i++) begin
      @(negedge o_clk);
      req_in  = vecs[i].req;
      data_in = vecs[i].data;
      o_ready = vecs[i].rdy;
      @(posedge o_clk);
      #1;
      check($sformatf("vec%0d_ack", i), 8'(ack_out), 8'(vecs[i].exp_ack));
      check($sformatf("vec%0d_valid", i), 8'(o_valid), 8'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_data", i), o_data, vecs[i].exp_data);
      end
    end

    // Burst fill with the consumer stalled.
    @(negedge o_clk);
    o_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send(8'(i), edges);
      check($sformatf("burst%0d_latency", i), 8'(edges), 8'd3);
`ifdef CDC_RX_LEVEL_EN
      check($sformatf("burst%0d_level", i), 8'(o_level), 8'(i));
      check($sformatf("burst%0d_full", i), 8'(o_full), 8'(i == 4));
`endif
    end
    @(negedge o_clk);
    data_in = 8'h05;
    req_in  = ~req_in;
    repeat (6) @(posedge o_clk);
    #1;
    check("full_ack_held", 8'(ack_out ^ req_in), 8'h01);
    check("full_valid", 8'(o_valid), 8'h01);
    check("full_head", o_data, 8'h01);
    @(negedge o_clk);
    o_ready = 1'b1;
    #1;
    got.delete();
    if (o_valid) got.push_back(o_data);
    for (int k = 0; k < 8; k++) begin
      @(posedge o_clk);
      #1;
      if (k == 0) begin
        check("fifth_ack_not_yet", 8'(ack_out ^ req_in), 8'h01);
`ifdef CDC_RX_LEVEL_EN
        check("pop_level", 8'(o_level), 8'd3);
        check("pop_full", 8'(o_full), 8'h00);
`endif
      end
      if (k == 1) check("fifth_ack", 8'(ack_out), 8'(req_in));
      if (o_valid) got.push_back(o_data);
    end
    check("burst_count", 8'(got.size()), 8'd5);
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      check($sformatf("burst_word%0d", i), got[i], 8'(i + 1));
    end

    // Simultaneous push and pop while holding two words.
    @(negedge o_clk);
    o_ready = 1'b0;
    send(8'h21, edges);
    send(8'h22, edges);
    @(negedge o_clk);
    data_in = 8'h23;
    req_in  = ~req_in;
    @(posedge o_clk);
    @(posedge o_clk);
    @(negedge o_clk);
    o_ready = 1'b1;
    @(posedge o_clk);
    #1;
    check("simul_ack", 8'(ack_out), 8'(req_in));
    check("simul_valid", 8'(o_valid), 8'h01);
    check("simul_head", o_data, 8'h22);
`ifdef CDC_RX_LEVEL_EN
    check("simul_level", 8'(o_level), 8'd2);
`endif
    got.delete();
    @(negedge o_clk);
    if (o_valid) got.push_back(o_data);
    repeat (4) begin
      @(posedge o_clk);
      #1;
      if (o_valid) got.push_back(o_data);
    end
    check("simul_count", 8'(got.size()), 8'd2);
    if (got.size() == 2) begin
      check("simul_word0", got[0], 8'h22);
      check("simul_word1", got[1], 8'h23);
    end

    // Reset while three words are buffered and a req is still being synchronised.
    @(negedge o_clk);
    o_ready = 1'b0;
    send(8'h31, edges);
    send(8'h32, edges);
    send(8'h33, edges);
    check("prereset_ack", 8'(ack_out), 8'h01);
    @(negedge o_clk);
    data_in = 8'h34;
    req_in  = ~req_in;
    @(posedge o_clk);
    #2;
    o_rst = 1'b1;
    #1;
    check("rst_valid", 8'(o_valid), 8'h00);
    check("rst_ack", 8'(ack_out), 8'h00);
`ifdef CDC_RX_LEVEL_EN
    check("rst_level", 8'(o_level), 8'h00);
`endif
    req_in  = 1'b1;
    data_in = 8'h3C;
    @(negedge o_clk);
    o_rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge o_clk);
      #1;
      check($sformatf("rel_ack_e%0d", k), 8'(ack_out), 8'(k == 3));
    end
    check("rel_valid", 8'(o_valid), 8'h01);
    check("rel_data", o_data, 8'h3C);
    @(negedge o_clk);
    o_ready = 1'b1;
    @(posedge o_clk);
    #1;
    check("rel_drained", 8'(o_valid), 8'h00);

    // Stream ten words against a consumer that is ready every other cycle.
    got.delete();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(8'(8'h10 + i), edges);
        end
      end
      begin
        int cyc;
        cyc = 0;
        while (got.size() < 10 && cyc < 400) begin
          @(negedge o_clk);
          o_ready = (cyc[0] == 1'b0);
          #1;
          if (o_valid && o_ready) got.push_back(o_data);
          cyc++;
        end
      end
    join
    check("wrap_count", 8'(got.size()), 8'd10);
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      check($sformatf("wrap_word%0d", i), got[i], 8'(8'h10 + i));
    end
    @(posedge o_clk);
    #1;
    check("wrap_empty", 8'(o_valid), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
